// File: rtl/inta_cycle_master.sv
// CPU-side 8259 interrupt-acknowledge initiator: drives the INTA# pulse train,
// captures the PIC data bytes and presents the resulting vector or CALL address.
module inta_cycle_master #(
    parameter int unsigned PULSE_W = 2,
    parameter int unsigned GAP_W   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        int_req,
    input  logic        ien,
    input  logic        mode_8080,
    input  logic [7:0]  data_in,
    output logic        inta_n,
    output logic        busy,
    output logic [15:0] vector,
    output logic        vector_valid,
    output logic        call_err
);

    localparam int unsigned MAX_W = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int unsigned CW    = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam logic [CW-1:0] LOW_LAST = CW'(PULSE_W - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_W - 1);
    localparam logic [7:0]    CALL_OP  = 8'hCD;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        GAP,
        DONE
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cyc_q;
    logic [1:0]    pnum_q;
    logic          mode_q;
    logic          sync1_q;
    logic          int_s_q;
    logic [7:0]    op_q;
    logic [7:0]    lo_q;
    logic [7:0]    hi_q;
    logic          inta_n_q;
    logic          busy_q;
    logic          valid_q;
    logic          err_q;
    logic [15:0]   vector_q;
    logic [1:0]    last_pnum;

    assign last_pnum    = mode_q ? 2'd2 : 2'd1;
    assign inta_n       = inta_n_q;
    assign busy         = busy_q;
    assign vector       = vector_q;
    assign vector_valid = valid_q;
    assign call_err     = err_q;

    // Two-flop synchronizer for the asynchronous INT level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            int_s_q <= 1'b0;
        end else begin
            sync1_q <= int_req;
            int_s_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cyc_q    <= '0;
            pnum_q   <= 2'd0;
            mode_q   <= 1'b0;
            op_q     <= 8'h00;
            lo_q     <= 8'h00;
            hi_q     <= 8'h00;
            inta_n_q <= 1'b1;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            vector_q <= 16'h0000;
        end else begin
            case (state_q)
                IDLE: begin
                    if (int_s_q && ien) begin
                        state_q  <= LOW;
                        cyc_q    <= '0;
                        pnum_q   <= 2'd0;
                        mode_q   <= mode_8080;
                        inta_n_q <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                LOW: begin
                    // Bytes are captured on the edge that releases INTA#.
                    if (cyc_q == LOW_LAST) begin
                        state_q  <= GAP;
                        cyc_q    <= '0;
                        inta_n_q <= 1'b1;
                        case (pnum_q)
                            2'd0:    op_q <= data_in;
                            2'd1:    lo_q <= data_in;
                            default: hi_q <= data_in;
                        endcase
                    end else begin
                        cyc_q <= cyc_q + CW'(1);
                    end
                end
                GAP: begin
                    if (cyc_q == GAP_LAST) begin
                        cyc_q <= '0;
                        if (pnum_q != last_pnum) begin
                            state_q  <= LOW;
                            pnum_q   <= pnum_q + 2'd1;
                            inta_n_q <= 1'b0;
                        end else begin
                            state_q  <= DONE;
                            valid_q  <= 1'b1;
                            vector_q <= mode_q ? {hi_q, lo_q} : {8'h00, lo_q};
                            err_q    <= mode_q && (op_q != CALL_OP);
                        end
                    end else begin
                        cyc_q <= cyc_q + CW'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q  <= IDLE;
                    inta_n_q <= 1'b1;
                    busy_q   <= 1'b0;
                    valid_q  <= 1'b0;
                    err_q    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inta_cycle_master.sv
// Directed bench for inta_cycle_master: a PIC data responder, pulse-width monitor
// and a scoreboard of expected vectors checked on every vector_valid strobe.
module tb_inta_cycle_master;

    localparam int PW0 = 2;
    localparam int GW0 = 2;
    localparam int PW1 = 3;
    localparam int GW1 = 1;

    typedef struct packed {
        logic [15:0] vec;
        logic        err;
        logic [1:0]  n;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    logic        int_req, ien, mode_8080;
    logic [7:0]  data_in;
    logic        inta_n, busy, vector_valid, call_err;
    logic [15:0] vector;

    logic        b_int_req, b_ien, b_mode_8080;
    logic [7:0]  b_data_in;
    logic        b_inta_n, b_busy, b_vector_valid, b_call_err;
    logic [15:0] b_vector;

    always #5 clk = ~clk;

    inta_cycle_master #(.PULSE_W(PW0), .GAP_W(GW0)) u_dut_a (
        .clk(clk), .reset(reset), .int_req(int_req), .ien(ien),
        .mode_8080(mode_8080), .data_in(data_in), .inta_n(inta_n), .busy(busy),
        .vector(vector), .vector_valid(vector_valid), .call_err(call_err)
    );

    inta_cycle_master #(.PULSE_W(PW1), .GAP_W(GW1)) u_dut_b (
        .clk(clk), .reset(reset), .int_req(b_int_req), .ien(b_ien),
        .mode_8080(b_mode_8080), .data_in(b_data_in), .inta_n(b_inta_n), .busy(b_busy),
        .vector(b_vector), .vector_valid(b_vector_valid), .call_err(b_call_err)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    exp_t       a_q[$];
    exp_t       b_q[$];
    logic [7:0] a_bytes [3];
    logic [7:0] b_bytes [3];

    int   lo_cnt [2];
    int   hi_cnt [2];
    int   idx [2];
    int   rise [2];
    int   since [2];
    int   strobes [2];
    int   strobe_cyc [2];
    logic prev_n [2];
    logic prev_b [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Per-instance responder and monitor, evaluated once per falling clock edge.
    task automatic serve(input int i);
        logic        n, bs, vv, ce;
        logic [15:0] vec;
        int          pw, gw;
        exp_t        e;
        n   = (i == 0) ? inta_n : b_inta_n;
        bs  = (i == 0) ? busy : b_busy;
        vv  = (i == 0) ? vector_valid : b_vector_valid;
        ce  = (i == 0) ? call_err : b_call_err;
        vec = (i == 0) ? vector : b_vector;
        pw  = (i == 0) ? PW0 : PW1;
        gw  = (i == 0) ? GW0 : GW1;
        if (reset) begin
            lo_cnt[i] = 0;
            hi_cnt[i] = 0;
            idx[i]    = 0;
            prev_n[i] = 1'b1;
            prev_b[i] = 1'b0;
        end else begin
            if (!bs) begin
                idx[i]    = 0;
                hi_cnt[i] = 0;
            end
            if (bs && !prev_b[i]) begin
                rise[i]  = cyc;
                since[i] = cyc - strobe_cyc[i];
            end
            if (!n) begin
                if (prev_n[i]) begin
                    if (hi_cnt[i] != 0) chk("gap_width", hi_cnt[i], gw);
                    hi_cnt[i] = 0;
                    if (idx[i] < 3) begin
                        if (i == 0) data_in = a_bytes[idx[i]];
                        else        b_data_in = b_bytes[idx[i]];
                    end
                    idx[i]++;
                end
                lo_cnt[i]++;
            end else begin
                if (lo_cnt[i] != 0) chk("pulse_width", lo_cnt[i], pw);
                lo_cnt[i] = 0;
                if (bs) hi_cnt[i]++;
            end
            if (ce && !vv) chk("call_err_stray", 32'(ce), 0);
            if (vv) begin
                strobes[i]++;
                strobe_cyc[i] = cyc;
                if (((i == 0) ? a_q.size() : b_q.size()) == 0) begin
                    chk("unexpected_strobe", 32'(vv), 0);
                end else begin
                    e = (i == 0) ? a_q.pop_front() : b_q.pop_front();
                    chk("vector", 32'(vec), 32'(e.vec));
                    chk("call_err", 32'(ce), 32'(e.err));
                    chk("strobe_time", cyc - rise[i], int'(e.n) * (pw + gw));
                    chk("busy_at_strobe", 32'(bs), 1);
                end
            end
            prev_n[i] = n;
            prev_b[i] = bs;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        serve(0);
        serve(1);
    endtask

    task automatic wait_busy(input int i, input int budget);
        int k = 0;
        while (((i == 0) ? busy : b_busy) !== 1'b1 && k < budget) begin
            tick();
            k++;
        end
        if (k >= budget) chk("busy_timeout", 32'((i == 0) ? busy : b_busy), 1);
    endtask

    task automatic wait_idle(input int i, input int budget);
        int k = 0;
        while ((((i == 0) ? a_q.size() : b_q.size()) != 0 ||
                ((i == 0) ? busy : b_busy) !== 1'b0) && k < budget) begin
            tick();
            k++;
        end
        if (k >= budget) chk("idle_timeout", (i == 0) ? a_q.size() : b_q.size(), 0);
    endtask

    initial begin
        int k;
        int base;
        reset = 1'b1;
        int_req = 1'b0;   ien = 1'b0;   mode_8080 = 1'b0;   data_in = 8'h00;
        b_int_req = 1'b0; b_ien = 1'b0; b_mode_8080 = 1'b0; b_data_in = 8'h00;
        for (int i = 0; i < 2; i++) begin
            lo_cnt[i] = 0; hi_cnt[i] = 0; idx[i] = 0; rise[i] = 0; since[i] = 0;
            strobes[i] = 0; strobe_cyc[i] = -100; prev_n[i] = 1'b1; prev_b[i] = 1'b0;
        end
        a_bytes = '{8'h00, 8'h00, 8'h00};
        b_bytes = '{8'h00, 8'h00, 8'h00};

        tick();
        tick();
        chk("rst_inta_n", 32'(inta_n), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_vector", 32'(vector), 0);
        chk("rst_valid", 32'(vector_valid), 0);
        chk("rst_call_err", 32'(call_err), 0);
        reset = 1'b0;
        tick();
        tick();

        // 8086 acknowledge: discard byte 0, vector from byte 1.
        a_bytes = '{8'hFF, 8'h4A, 8'h00};
        a_q.push_back('{vec: 16'h004A, err: 1'b0, n: 2'd2});
        base = cyc;
        int_req = 1'b1;
        ien = 1'b1;
        wait_busy(0, 10);
        chk("e0_latency", rise[0] - base, 3);
        int_req = 1'b0;
        wait_idle(0, 30);

        // 8080 CALL sequence; mode changed mid-sequence must be ignored.
        a_bytes = '{8'hCD, 8'h34, 8'h12};
        a_q.push_back('{vec: 16'h1234, err: 1'b0, n: 2'd3});
        mode_8080 = 1'b1;
        int_req = 1'b1;
        wait_busy(0, 10);
        mode_8080 = 1'b0;
        int_req = 1'b0;
        wait_idle(0, 40);

        a_bytes = '{8'hC3, 8'h34, 8'h12};
        a_q.push_back('{vec: 16'h1234, err: 1'b1, n: 2'd3});
        mode_8080 = 1'b1;
        int_req = 1'b1;
        wait_busy(0, 10);
        int_req = 1'b0;
        wait_idle(0, 40);
        mode_8080 = 1'b0;

        // Interrupts disabled: nothing happens until ien rises.
        ien = 1'b0;
        int_req = 1'b1;
        k = 0;
        for (int j = 0; j < 20; j++) begin
            tick();
            if (inta_n !== 1'b1 || busy !== 1'b0) k++;
        end
        chk("ien0_quiet", k, 0);
        a_bytes = '{8'hFF, 8'h5C, 8'h00};
        a_q.push_back('{vec: 16'h005C, err: 1'b0, n: 2'd2});
        base = cyc;
        ien = 1'b1;
        wait_busy(0, 10);
        chk("ien_start_latency", rise[0] - base, 1);
        int_req = 1'b0;
        wait_idle(0, 30);

        // Request and enable dropped during pulse 0 do not abort.
        a_bytes = '{8'hFF, 8'h47, 8'h00};
        a_q.push_back('{vec: 16'h0047, err: 1'b0, n: 2'd2});
        int_req = 1'b1;
        wait_busy(0, 10);
        chk("in_pulse0", 32'(inta_n), 0);
        int_req = 1'b0;
        ien = 1'b0;
        wait_idle(0, 30);

        // Reset during the second LOW: immediate release, no strobe, vector cleared.
        a_bytes = '{8'hFF, 8'h99, 8'h00};
        int_req = 1'b1;
        ien = 1'b1;
        wait_busy(0, 10);
        int_req = 1'b0;
        ien = 1'b0;
        k = 0;
        while (idx[0] < 2 && k < 20) begin
            tick();
            k++;
        end
        chk("reached_pulse1", idx[0], 2);
        chk("in_pulse1", 32'(inta_n), 0);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_inta_n", 32'(inta_n), 1);
        chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_vector", 32'(vector), 0);
        tick();
        tick();
        reset = 1'b0;
        base = strobes[0];
        for (int j = 0; j < 20; j++) tick();
        chk("no_strobe_after_rst", strobes[0] - base, 0);
        chk("vector_after_rst", 32'(vector), 0);

        // Back-to-back acknowledges on the PW=3, GW=1 instance.
        b_bytes = '{8'hFF, 8'h21, 8'h00};
        b_q.push_back('{vec: 16'h0021, err: 1'b0, n: 2'd2});
        b_q.push_back('{vec: 16'h0021, err: 1'b0, n: 2'd2});
        b_int_req = 1'b1;
        b_ien = 1'b1;
        k = 0;
        while (strobes[1] < 1 && k < 50) begin
            tick();
            k++;
        end
        chk("b_first_strobe", strobes[1], 1);
        wait_busy(1, 10);
        b_int_req = 1'b0;
        wait_idle(1, 50);
        chk("b2b_restart", since[1], 2);
        chk("b_strobes", strobes[1], 2);

        for (int j = 0; j < 10; j++) tick();
        chk("a_sb_empty", a_q.size(), 0);
        chk("b_sb_empty", b_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
